imm_decode_ctrl: RTL
====================

IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr  input  32  MIPS instruction word; opcode = instr[31:26], imm16 = instr[15:0].
REQ-007 flush  input  1  synchronous discard of all buffered entries.
REQ-008 out_valid  output  1  head entry valid downstream.
REQ-009 out_ready  input  1  downstream accepts the head entry.
REQ-010 out_instr  output  32  instruction word of the head entry.
REQ-011 imm32  output  32  extended immediate of the head entry.
REQ-012 sign_ext  output  1  extension mode used for the head entry (1 = sign, 0 = zero/none).
REQ-013 imm_kind  output  2  immediate kind: 00 ZEXT, 01 SEXT, 10 LUI, 11 NONE.
REQ-014 illegal  output  1  head entry opcode is not in the decode table.
REQ-015 dec_cnt  output  16  count of entries delivered downstream.

Function
REQ-016 The block SHALL decode each accepted instruction combinationally at the input and store the decoded result in a 2-entry FIFO (skid buffer); all outputs SHALL come from the head entry.
REQ-017 Decode table:
- SEXT, sign_ext=1: opcodes 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x23, 0x2B.
- ZEXT, sign_ext=0: opcodes 0x0C, 0x0D, 0x0E.
- LUI, sign_ext=0: opcode 0x0F.
- NONE, sign_ext=0: opcodes 0x00, 0x02, 0x03.
- Every other opcode: NONE, sign_ext=0, illegal=1.
REQ-018 imm32 SHALL be:
- SEXT: {16{imm16[15]}, imm16}.
- ZEXT: {16'h0000, imm16}.
- LUI: {imm16, 16'h0000}.
- NONE: 32'h0000_0000.
REQ-019 The FSM SHALL have states EMPTY (0 entries), ONE (1 entry) and TWO (2 entries).
REQ-020 Accept condition: in_valid & in_ready. Deliver condition: out_valid & out_ready.
REQ-021 State transitions:
- EMPTY + accept -> ONE.
- ONE + accept, no deliver -> TWO.
- ONE + deliver, no accept -> EMPTY.
- ONE + accept + deliver -> ONE.
- TWO + deliver -> ONE.
- Otherwise the state holds.
REQ-022 in_ready SHALL be a registered signal, equal to 1 exactly when the state is not TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-023 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-024 Latency: an instruction accepted in cycle N SHALL appear at the head in cycle N+1 when the FIFO was empty.
REQ-025 Ordering: entries SHALL be delivered strictly in acceptance order.
REQ-026 Hold: while out_valid=1 and out_ready=0, all head outputs SHALL remain stable.
REQ-027 flush SHALL take priority over accept and deliver in the same cycle: the state goes to EMPTY, no entry is stored, dec_cnt does not increment, and in_ready=1 on the next cycle.
REQ-028 dec_cnt SHALL increment by 1 on each deliver and wrap from 16'hFFFF to 16'h0000; illegal entries are counted.
REQ-029 When out_valid=0, imm32, out_instr, imm_kind, sign_ext and illegal SHALL all read 0.

Reset
REQ-030 Asserting rst_n low SHALL, asynchronously and regardless of clk:
- set the state to EMPTY;
- set out_valid=0, in_ready=0, dec_cnt=0, and all data outputs to 0.
REQ-031 On the first rising edge after rst_n is released, in_ready SHALL become 1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; no partial entry SHALL be delivered after reset is released.

Verification
REQ-033 ADDI with imm 0xFFF0 (instr 0x2001FFF0), out_ready=1 -> next cycle: out_valid=1, imm32=0xFFFFFFF0, imm_kind=01, sign_ext=1, dec_cnt increments.
REQ-034 ORI 0x3421_8000, then LUI 0x3C01_1234, out_ready=1 -> imm32 values in order:
- 0x00008000, imm_kind=00.
- 0x12340000, imm_kind=10.
REQ-035 Back-pressure: out_ready=0 with three back-to-back valid instructions ->
- first two accepted;
- in_ready=0 from the cycle after the second accept;
- third instruction held upstream;
- head stable.
- After out_ready=1, all three are delivered in order.
REQ-036 Opcode 0x3F (instr 0xFC00_0001) -> illegal=1, imm_kind=11, imm32=0, dec_cnt increments on deliver.
REQ-037 FIFO in state TWO; flush=1 and in_valid=1 in the same cycle -> next cycle: out_valid=0, in_ready=1, dec_cnt unchanged.
REQ-038 Preload dec_cnt to 0xFFFF via 65535 delivers, then one more deliver -> dec_cnt=0x0000; rst_n low mid-stream -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_decode_if.sv
// Handshake bus for the immediate decoder: upstream instruction stream in,
// decoded head entry out.
interface imm_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] imm32;
    logic        sign_ext;
    logic [1:0]  imm_kind;
    logic        illegal;
    logic [15:0] dec_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output instr,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  imm32,
        input  sign_ext,
        input  imm_kind,
        input  illegal,
        input  dec_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  instr,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_instr,
        output imm32,
        output sign_ext,
        output imm_kind,
        output illegal,
        output dec_cnt
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// MIPS immediate decoder: decodes at the input, buffers results in a 2-entry
// skid FIFO and presents the head entry downstream with a delivery counter.
module imm_decode_ctrl (
    input logic         clk,
    input logic         rst_n,
    imm_decode_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [1:0] KindZext = 2'b00;
    localparam logic [1:0] KindSext = 2'b01;
    localparam logic [1:0] KindLui  = 2'b10;
    localparam logic [1:0] KindNone = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic        sign_ext;
        logic [1:0]  kind;
        logic        illegal;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    entry_t      dec;
    logic        in_ready_q, in_ready_d;
    logic [15:0] cnt_q, cnt_d;
    logic        out_valid;
    logic        accept;
    logic        deliver;
    logic [15:0] imm16;

    always_comb begin
        dec       = '0;
        dec.instr = bus.instr;
        dec.kind  = KindNone;
        imm16     = bus.instr[15:0];
        case (bus.instr[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                dec.kind     = KindSext;
                dec.sign_ext = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: dec.kind = KindZext;
            6'h0F:               dec.kind = KindLui;
            6'h00, 6'h02, 6'h03: dec.kind = KindNone;
            default:             dec.illegal = 1'b1;
        endcase
        unique case (dec.kind)
            KindSext: dec.imm32 = {{16{imm16[15]}}, imm16};
            KindZext: dec.imm32 = {16'h0000, imm16};
            KindLui:  dec.imm32 = {imm16, 16'h0000};
            default:  dec.imm32 = 32'h0000_0000;
        endcase
    end

    assign out_valid = (state_q != StEmpty);
    assign accept    = bus.in_valid & in_ready_q;
    assign deliver   = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            if (deliver) cnt_d = cnt_q + 16'd1;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && deliver) begin
                        head_d = dec;
                    end else if (accept) begin
                        tail_d  = dec;
                        state_d = StTwo;
                    end else if (deliver) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (deliver) begin
                        head_d  = tail_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Registered ready: looks ahead at the next state, never at out_ready.
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? head_q.instr : 32'h0;
    assign bus.imm32     = out_valid ? head_q.imm32 : 32'h0;
    assign bus.sign_ext  = out_valid & head_q.sign_ext;
    assign bus.imm_kind  = out_valid ? head_q.kind : 2'b00;
    assign bus.illegal   = out_valid & head_q.illegal;
    assign bus.dec_cnt   = cnt_q;

endmodule
